// File: rtl/cpu_pkg.sv
// Shared definitions for the pipeline sequencer: FSM encoding, default widths
// and the statistics counter reset value.
package cpu_pkg;

    localparam int RW = 5;
    localparam int CW = 32;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam logic [CW-1:0] CNT_RST = '0;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard sequencer: hazard
// sources from ID/EX/WB in, stage enables/clears and panel statistics out.
interface pipeline_hazard_ctrl_if #(
    parameter int RW = cpu_pkg::RW,
    parameter int CW = cpu_pkg::CW
);

    logic [RW-1:0] in_id_rs;
    logic [RW-1:0] in_id_rt;
    logic          in_id_use_rs;
    logic          in_id_use_rt;
    logic          in_ex_memread;
    logic [RW-1:0] in_ex_rw;
    logic          in_ex_redirect;
    logic          in_halt;
    logic          in_go;

    logic          out_pc_en;
    logic          out_ifid_en;
    logic          out_idex_en;
    logic          out_exmem_en;
    logic          out_memwb_en;
    logic          out_ifid_clr;
    logic          out_idex_clr;
    logic          out_exmem_clr;
    logic          out_memwb_clr;
    logic          out_halted;
    logic [CW-1:0] out_cycles;
    logic [CW-1:0] out_stalls;
    logic [CW-1:0] out_flushes;

    // The sequencer is the master of the control outputs.
    modport master (
        input  in_id_rs, in_id_rt, in_id_use_rs, in_id_use_rt,
        input  in_ex_memread, in_ex_rw, in_ex_redirect, in_halt, in_go,
        output out_pc_en, out_ifid_en, out_idex_en, out_exmem_en, out_memwb_en,
        output out_ifid_clr, out_idex_clr, out_exmem_clr, out_memwb_clr,
        output out_halted, out_cycles, out_stalls, out_flushes
    );

    modport slave (
        output in_id_rs, in_id_rt, in_id_use_rs, in_id_use_rt,
        output in_ex_memread, in_ex_rw, in_ex_redirect, in_halt, in_go,
        input  out_pc_en, out_ifid_en, out_idex_en, out_exmem_en, out_memwb_en,
        input  out_ifid_clr, out_idex_clr, out_exmem_clr, out_memwb_clr,
        input  out_halted, out_cycles, out_stalls, out_flushes
    );

endinterface

// File: rtl/perf_counter.sv
// Free-running statistics counter with synchronous clear; wraps modulo 2^W.
module perf_counter
    import cpu_pkg::*;
#(
    parameter int W = CW
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clock) begin
        if (clear) begin
            count <= W'(CNT_RST);
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline sequencer: load-use stalls, redirect flushes,
// halt/resume, and the cycle/stall/flush panel counters.
module pipeline_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int CW = cpu_pkg::CW,
    parameter int RW = cpu_pkg::RW
) (
    input logic                   in_CLK,
    input logic                   in_CLR,
    pipeline_hazard_ctrl_if.master bus
);

    state_t state;
    state_t state_next;
    logic   lu;
    logic   rd;
    logic   cyc_inc;
    logic   stall_inc;
    logic   flush_inc;

    // Register 0 is hardwired to zero, so a load targeting it never conflicts.
    always_comb begin
        lu = bus.in_ex_memread & (bus.in_ex_rw != RW'(0)) &
             ((bus.in_id_use_rs & (bus.in_id_rs == bus.in_ex_rw)) |
              (bus.in_id_use_rt & (bus.in_id_rt == bus.in_ex_rw)));
        rd = bus.in_ex_redirect;
    end

    always_ff @(posedge in_CLK) begin
        if (in_CLR) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (bus.in_halt) state_next = HALT;
            HALT:    if (bus.in_go)   state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        bus.out_pc_en     = 1'b0;
        bus.out_ifid_en   = 1'b0;
        bus.out_idex_en   = 1'b0;
        bus.out_exmem_en  = 1'b0;
        bus.out_memwb_en  = 1'b0;
        bus.out_ifid_clr  = 1'b0;
        bus.out_idex_clr  = 1'b0;
        bus.out_exmem_clr = 1'b0;
        bus.out_memwb_clr = 1'b0;
        cyc_inc           = 1'b0;
        stall_inc         = 1'b0;
        flush_inc         = 1'b0;
        if (in_CLR) begin
            bus.out_ifid_clr  = 1'b1;
            bus.out_idex_clr  = 1'b1;
            bus.out_exmem_clr = 1'b1;
            bus.out_memwb_clr = 1'b1;
        end else if (state == RUN) begin
            cyc_inc = 1'b1;
            if (bus.in_halt) begin
                cyc_inc = 1'b1;
            end else if (rd) begin
                // A coincident load-use is dropped: that instruction is squashed.
                bus.out_pc_en    = 1'b1;
                bus.out_ifid_en  = 1'b1;
                bus.out_idex_en  = 1'b1;
                bus.out_exmem_en = 1'b1;
                bus.out_memwb_en = 1'b1;
                bus.out_ifid_clr = 1'b1;
                bus.out_idex_clr = 1'b1;
                flush_inc        = 1'b1;
            end else if (lu) begin
                bus.out_idex_en  = 1'b1;
                bus.out_exmem_en = 1'b1;
                bus.out_memwb_en = 1'b1;
                bus.out_idex_clr = 1'b1;
                stall_inc        = 1'b1;
            end else begin
                bus.out_pc_en    = 1'b1;
                bus.out_ifid_en  = 1'b1;
                bus.out_idex_en  = 1'b1;
                bus.out_exmem_en = 1'b1;
                bus.out_memwb_en = 1'b1;
            end
        end
    end

    assign bus.out_halted = (state == HALT);

    perf_counter #(.W(CW)) u_cycles (
        .clock (in_CLK),
        .clear (in_CLR),
        .inc   (cyc_inc),
        .count (bus.out_cycles)
    );

    perf_counter #(.W(CW)) u_stalls (
        .clock (in_CLK),
        .clear (in_CLR),
        .inc   (stall_inc),
        .count (bus.out_stalls)
    );

    perf_counter #(.W(CW)) u_flushes (
        .clock (in_CLK),
        .clear (in_CLR),
        .inc   (flush_inc),
        .count (bus.out_flushes)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: each driven cycle queues its
// expected outputs, and a negedge monitor pops and compares them.
module tb_pipeline_hazard_ctrl;

    typedef struct {
        logic [8:0]  ctrl;
        logic [8:0]  mask;
        logic        cnt_known;
        logic        halted;
        logic [31:0] cycles;
        logic [31:0] stalls;
        logic [31:0] flushes;
        logic        hand;
        logic        h_halted;
        logic [31:0] h_cycles;
        logic [31:0] h_stalls;
        logic [31:0] h_flushes;
    } exp_t;

    logic clk;
    logic clr;
    exp_t exp_q[$];
    int   tests;
    int   fails;

    logic        m_known;
    logic        m_halted;
    logic [31:0] m_cyc;
    logic [31:0] m_stl;
    logic [31:0] m_fl;

    logic        hand_pend;
    logic        hand_halted;
    logic [31:0] hand_cyc;
    logic [31:0] hand_stl;
    logic [31:0] hand_fl;

    pipeline_hazard_ctrl_if #(.RW(5), .CW(32)) bus ();

    pipeline_hazard_ctrl #(.CW(32), .RW(5)) dut (
        .in_CLK (clk),
        .in_CLR (clr),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Queues a hand-computed statistics check for the next driven cycle.
    task automatic expectStats(input logic [31:0] c, input logic [31:0] s, input logic [31:0] f, input logic h);
        hand_pend   = 1'b1;
        hand_cyc    = c;
        hand_stl    = s;
        hand_fl     = f;
        hand_halted = h;
    endtask

    task automatic applyStimulus(input logic c, input logic h, input logic g, input logic r,
                                 input logic mr, input logic [4:0] erw, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic urs, input logic urt);
        exp_t e;
        logic lu_m;
        @(posedge clk);
        #1;
        clr                = c;
        bus.in_halt        = h;
        bus.in_go          = g;
        bus.in_ex_redirect = r;
        bus.in_ex_memread  = mr;
        bus.in_ex_rw       = erw;
        bus.in_id_rs       = rs;
        bus.in_id_rt       = rt;
        bus.in_id_use_rs   = urs;
        bus.in_id_use_rt   = urt;
        lu_m = mr && (erw != 5'd0) && ((urs && rs == erw) || (urt && rt == erw));

        // ctrl bit order: pc, ifid_en, idex_en, exmem_en, memwb_en, ifid_clr, idex_clr, exmem_clr, memwb_clr
        if (c) begin
            e.ctrl = 9'b000001111; e.mask = 9'b111111111;
        end else if (m_halted || h) begin
            e.ctrl = 9'b000000000; e.mask = 9'b111111111;
        end else if (r) begin
            e.ctrl = 9'b100111100; e.mask = 9'b100111111;
        end else if (lu_m) begin
            e.ctrl = 9'b000110100; e.mask = 9'b110111111;
        end else begin
            e.ctrl = 9'b111110000; e.mask = 9'b111111111;
        end
        e.cnt_known = m_known;
        e.halted    = m_halted;
        e.cycles    = m_cyc;
        e.stalls    = m_stl;
        e.flushes   = m_fl;
        e.hand      = hand_pend;
        e.h_halted  = hand_halted;
        e.h_cycles  = hand_cyc;
        e.h_stalls  = hand_stl;
        e.h_flushes = hand_fl;
        hand_pend   = 1'b0;
        exp_q.push_back(e);

        if (c) begin
            m_known  = 1'b1;
            m_halted = 1'b0;
            m_cyc    = 32'd0;
            m_stl    = 32'd0;
            m_fl     = 32'd0;
        end else if (m_halted) begin
            if (g) m_halted = 1'b0;
        end else begin
            m_cyc = m_cyc + 32'd1;
            if (h)         m_halted = 1'b1;
            else if (r)    m_fl = m_fl + 32'd1;
            else if (lu_m) m_stl = m_stl + 32'd1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    endtask

    task automatic doReset();
        applyStimulus(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [8:0] act;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act = {bus.out_pc_en, bus.out_ifid_en, bus.out_idex_en, bus.out_exmem_en, bus.out_memwb_en,
                   bus.out_ifid_clr, bus.out_idex_clr, bus.out_exmem_clr, bus.out_memwb_clr};
            checkOutput("ctrl", {23'd0, act & e.mask}, {23'd0, e.ctrl & e.mask});
            if (e.cnt_known) begin
                checkOutput("halted", {31'd0, bus.out_halted}, {31'd0, e.halted});
                checkOutput("cycles", bus.out_cycles, e.cycles);
                checkOutput("stalls", bus.out_stalls, e.stalls);
                checkOutput("flushes", bus.out_flushes, e.flushes);
            end
            if (e.hand) begin
                checkOutput("hand_halted", {31'd0, bus.out_halted}, {31'd0, e.h_halted});
                checkOutput("hand_cycles", bus.out_cycles, e.h_cycles);
                checkOutput("hand_stalls", bus.out_stalls, e.h_stalls);
                checkOutput("hand_flushes", bus.out_flushes, e.h_flushes);
            end
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        m_known = 1'b0; m_halted = 1'b0;
        m_cyc = '0; m_stl = '0; m_fl = '0;
        hand_pend = 1'b0; hand_halted = 1'b0;
        hand_cyc = '0; hand_stl = '0; hand_fl = '0;
        clr = 1'b1;
        bus.in_halt = 0; bus.in_go = 0; bus.in_ex_redirect = 0; bus.in_ex_memread = 0;
        bus.in_ex_rw = 0; bus.in_id_rs = 0; bus.in_id_rt = 0; bus.in_id_use_rs = 0; bus.in_id_use_rt = 0;

        // Reset, then load-use on rs/rt and the non-hazard variants.
        doReset();
        expectStats(0, 0, 0, 0);
        idle(1);
        applyStimulus(0, 0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 1, 0);
        expectStats(2, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0);
        expectStats(3, 1, 0, 0);
        idle(1);
        applyStimulus(0, 0, 0, 0, 1, 5'd9, 5'd3, 5'd9, 0, 1);
        applyStimulus(0, 0, 0, 0, 1, 5'd4, 5'd4, 5'd0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 5'd4, 5'd4, 5'd0, 1, 0);
        expectStats(7, 2, 0, 0);
        idle(1);

        // Redirect with a coincident load-use.
        doReset();
        applyStimulus(0, 0, 0, 1, 1, 5'd8, 5'd8, 5'd0, 1, 0);
        expectStats(1, 0, 1, 0);
        idle(1);

        // Halt after 10 RUN cycles, ignored hazards while halted, then resume.
        doReset();
        idle(10);
        applyStimulus(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        expectStats(11, 0, 0, 1);
        for (int i = 0; i < 20; i++)
            applyStimulus(0, (i % 3) == 0, 0, (i % 2) == 1, 1, 5'd8, 5'd8, 5'd0, 1, 0);
        expectStats(11, 0, 0, 1);
        applyStimulus(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        expectStats(11, 0, 0, 0);
        idle(1);
        expectStats(12, 0, 0, 0);
        idle(1);

        // Halt and go together in RUN: halt wins and the FSM stays halted.
        applyStimulus(0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        expectStats(14, 0, 0, 1);
        idle(1);
        expectStats(14, 0, 0, 1);
        idle(1);

        // Five stalls, halt, then reset out of HALT with a load-use present.
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 1, 0);
        applyStimulus(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        expectStats(6, 5, 0, 1);
        idle(2);
        applyStimulus(1, 0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 1, 0);
        expectStats(0, 0, 0, 0);
        idle(1);
        idle(1);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
